mult_ser_deser: RTL and testbench
=================================

Name: mult_ser_deser

Overview:
- Bit-serial result deserializer for the sequential MAC datapath.
- Accepts the LSB-first serial product stream emitted by the bit-serial multiplier and reassembles it into an N-bit word.
- Presents the word on a valid/ready parallel interface to the accumulator/readout logic.
- Single-entry output holding register, so the next word can shift in while the previous one awaits acceptance.

Parameters:
- N, 16, serial bits per result word (N >= 1).
- W, 32, parallel output width (W >= N); upper W-N bits are filled per the Optional Feature.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_start  input  1  qualified by in_valid; marks the LSB (bit 0) of a new word.
- in_bit  input  1  serial result bit, LSB first.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  W  reassembled word.
- busy  output  1  a partial word is being shifted in.
- overrun  output  1  sticky: a completed word was dropped because the holding register was occupied.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, bit counter 0, shift register 0, out_valid 0, out_data 0, busy 0, overrun 0. Reset mid-word discards the partial word.
- Counter width is $clog2(N) with a minimum of 1. Shift register is N bits. Each accepted bit enters at position N-1 and the register shifts right, so after N bits bit 0 sits at position 0.
- FSM states IDLE and SHIFT.
- IDLE:
  - in_valid && in_start: capture bit 0, cnt=1, go to SHIFT.
  - If N==1, the word completes in this same cycle and the FSM stays in IDLE.
  - in_valid without in_start is ignored.
- SHIFT:
  - in_valid && !in_start: capture bit, cnt++.
  - in_valid && in_start: abort the partial word, restart with this bit as bit 0, cnt=1. No error is flagged.
  - !in_valid: stall; all state held.
- Completion: the cycle in which bit N-1 is captured.
  - The FSM returns to IDLE (or restarts, see next item).
  - The word transfers into the holding register if the register is empty, or if it drains in the same cycle (out_valid && out_ready). Otherwise the word is dropped and overrun is set to 1.
- The cycle after completion, in_start may begin the next word with no bubble.
- Latency: out_valid rises on the clock edge after bit N-1 is sampled.
- Output handshake:
  - out_data is stable while out_valid && !out_ready.
  - out_valid falls on the edge after acceptance, unless a new word loads on that same edge; in that case out_valid stays 1 and out_data updates.
- busy = (state==SHIFT).
- overrun:
  - Sticky.
  - Cleared only by reset or overrun_clr.
  - If overrun_clr and a new overrun occur in the same cycle, overrun ends at 1 (set wins).

Optional Feature:
- Macro: MULT_SER_DESER_SIGN_EXT_EN.
- Defined: out_data[W-1:N] = word bit N-1 (two's-complement sign extension).
- Undefined: out_data[W-1:N] = 0 (zero extension).
- When W==N the macro has no effect.

Decomposition:
- Package mult_ser_pkg holds:
  - state typedef enum {IDLE, SHIFT};
  - the log2 helper function shared with the MAC header.
- One natural sub-module: ser_hold_reg.
  - Single-entry valid/ready holding register with a load/drain-same-cycle rule.
  - Parameter W; outputs out_valid and out_data.
  - Reports load-refused, which drives the overrun set.

Test Plan (N=8, W=16):
- Single word, no stalls: 0xA5 sent as bits 1,0,1,0,0,1,0,1 with in_start on the first, out_ready=1. Required: out_valid=1 exactly one cycle after bit 7; out_data=0x00A5 (0xFFA5 with SIGN_EXT_EN); busy high for cycles 1..7.
- Gapped input: 0x3C sent with in_valid deasserted for 2 cycles after bits 2 and 5. Required: out_data=0x003C; out_valid delayed by exactly 4 cycles versus the gap-free case.
- Backpressure/overrun: out_ready=0, send 0x3C then 0x81 back-to-back. Required: out_data holds 0x003C; overrun=1 after 0x81 completes; 0x81 lost. Then pulse overrun_clr: overrun=0.
- Drain collision: out_valid with 0x0011, out_ready=1 in the same cycle that 0x22 completes. Required: next cycle out_valid=1, out_data=0x0022, overrun=0.
- Restart: in_start after 3 bits, then full word 0x5A. Required: only 0x005A is delivered; no overrun.
- Mid-word reset: rst low for 1 cycle after 4 bits. Required: all outputs 0 immediately. The next full word 0xC3 is then delivered as 0x00C3 (0xFFC3 with SIGN_EXT_EN).

Source files
------------

// File: rtl/mult_ser_pkg.sv
// Shared types and helpers for the bit-serial MAC result path.
package mult_ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // log2 for counter sizing, never narrower than one bit
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// Single-entry valid/ready holding register; a load is accepted
// when empty or when the current word drains on the same edge.
module ser_hold_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         refused_o
);

   logic         valid_q;
   logic [W-1:0] data_q;
   logic         accept;

   assign accept    = !valid_q || out_ready;
   assign refused_o = load_i && !accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i && accept) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/mult_ser_deser.sv
// LSB-first serial result deserializer with a one-word output buffer.
// MULT_SER_DESER_SIGN_EXT_EN: sign-extend words into out_data[W-1:N].
module mult_ser_deser
   import mult_ser_pkg::*;
#(
   parameter int N = 16,
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic         in_start,
   input  logic         in_bit,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         busy,
   output logic         overrun,
   input  logic         overrun_clr
);

   localparam int CW = clog2_min1(N);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  sr_q, sr_d;
   logic [N-1:0]  sh_w, st_w;
   logic [W-1:0]  ext_w;
   logic          done;
   logic          refused;
   logic          overrun_q;

   always_comb begin
      sh_w       = sr_q >> 1;
      sh_w[N-1]  = in_bit;
      st_w       = '0;
      st_w[N-1]  = in_bit;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_start) begin
               sr_d = st_w;
               if (N == 1) begin
                  done  = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d   = CW'(1);
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (in_valid && in_start) begin
               sr_d  = st_w;
               cnt_d = CW'(1);
            end else if (in_valid) begin
               sr_d = sh_w;
               if (cnt_q == CW'(N - 1)) begin
                  done    = 1'b1;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ext_w = W'(sr_d);
`ifdef MULT_SER_DESER_SIGN_EXT_EN
      for (int i = N; i < W; i++) ext_w[i] = sr_d[N-1];
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sr_q      <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         // a new drop outranks a same-cycle clear
         if (refused)          overrun_q <= 1'b1;
         else if (overrun_clr) overrun_q <= 1'b0;
      end
   end

   ser_hold_reg #(.W(W)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .load_i    (done),
      .data_i    (ext_w),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .refused_o (refused)
   );

   assign busy    = (state_q == SHIFT);
   assign overrun = overrun_q;

endmodule

// File: tb/tb_mult_ser_deser.sv
// Scoreboard bench for mult_ser_deser at N=8, W=16.
module tb_mult_ser_deser;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_start = 1'b0;
   logic        in_bit = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        busy;
   logic        overrun;
   logic        overrun_clr = 1'b0;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  busy_tr;
   logic        ov_before;
   int          lat1, lat2, lat_x;

   mult_ser_deser #(.N(8), .W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_start    (in_start),
      .in_bit      (in_bit),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] ext(input logic [7:0] b);
`ifdef MULT_SER_DESER_SIGN_EXT_EN
      return {{8{b[7]}}, b};
`else
      return {8'h00, b};
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [7:0] w, input bit gap,
                            input bit rdy7, output int lat);
      int t0;
      t0 = cyc;
      for (int i = 0; i < 8; i++) begin
         if (gap && (i == 3 || i == 6)) begin
            in_valid = 1'b0;
            in_start = 1'b0;
            idle(2);
         end
         in_valid = 1'b1;
         in_start = (i == 0);
         in_bit   = w[i];
         if (i == 7) begin
            ov_before = out_valid;
            if (rdy7) out_ready = 1'b1;
         end
         @(posedge clk);
         #1;
         busy_tr[i] = busy;
      end
      in_valid = 1'b0;
      in_start = 1'b0;
      lat = cyc - t0;
   endtask

   // monitor: every accepted word must match the oldest expectation
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected", {16'h0, out_data}, 32'hFFFF_FFFF);
         end else begin
            chk("sb_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      idle(2);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0);
      rst = 1'b1;
      idle(1);

      // single word, no stalls
      out_ready = 1'b1;
      exp_q.push_back(ext(8'hA5));
      send_word(8'hA5, 1'b0, 1'b0, lat1);
      chk("t1_valid_before", ov_before, 0);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, ext(8'hA5));
      chk("t1_busy_trace", busy_tr, 8'h7F);
      chk("t1_latency", lat1, 8);
      idle(2);
      chk("t1_drained", out_valid, 0);

      // gapped input
      exp_q.push_back(ext(8'h3C));
      send_word(8'h3C, 1'b1, 1'b0, lat2);
      chk("t2_valid", out_valid, 1);
      chk("t2_delay", lat2 - lat1, 4);
      idle(2);

      // backpressure and overrun
      out_ready = 1'b0;
      exp_q.push_back(ext(8'h3C));
      send_word(8'h3C, 1'b0, 1'b0, lat_x);
      chk("t3_ovr_first", overrun, 0);
      send_word(8'h81, 1'b0, 1'b0, lat_x);
      chk("t3_ovr_set", overrun, 1);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, ext(8'h3C));
      idle(3);
      chk("t3_ovr_sticky", overrun, 1);
      overrun_clr = 1'b1;
      idle(1);
      overrun_clr = 1'b0;
      chk("t3_ovr_clr", overrun, 0);
      out_ready = 1'b1;
      idle(1);
      chk("t3_drained", out_valid, 0);

      // drain collides with completion
      out_ready = 1'b0;
      exp_q.push_back(ext(8'h11));
      send_word(8'h11, 1'b0, 1'b0, lat_x);
      exp_q.push_back(ext(8'h22));
      send_word(8'h22, 1'b0, 1'b1, lat_x);
      chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, ext(8'h22));
      chk("t4_ovr", overrun, 0);
      idle(2);

      // restart after three bits
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_start = 1'b1;
      in_bit   = 1'b1;
      idle(1);
      in_start = 1'b0;
      idle(2);
      chk("t5_busy_mid", busy, 1);
      exp_q.push_back(ext(8'h5A));
      send_word(8'h5A, 1'b0, 1'b0, lat_x);
      chk("t5_data", out_data, ext(8'h5A));
      chk("t5_ovr", overrun, 0);
      idle(2);

      // mid-word reset with a pending word and overrun set
      out_ready = 1'b0;
      send_word(8'h7E, 1'b0, 1'b0, lat_x);
      send_word(8'h01, 1'b0, 1'b0, lat_x);
      in_valid = 1'b1;
      in_start = 1'b1;
      in_bit   = 1'b1;
      idle(1);
      in_start = 1'b0;
      idle(3);
      in_valid = 1'b0;
      chk("t6_pre_state", {busy, overrun, out_valid}, 3'b111);
      rst = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_data", out_data, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_ovr", overrun, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(ext(8'hC3));
      send_word(8'hC3, 1'b0, 1'b0, lat_x);
      chk("t6_data", out_data, ext(8'hC3));
      idle(3);

      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
